// File: rtl/wiegand_pkg.sv
// rtl/wiegand_pkg.sv - shared types and default timing for the Wiegand receive path
package wiegand_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOW       = 2'd1,
        WAIT_HIGH = 2'd2,
        ERR       = 2'd3
    } wg_state_t;

    // Lane index doubles as the decoded bit value: wil[0] low is a 0, wil[1] low is a 1.
    typedef enum logic {
        LANE_ZERO = 1'b0,
        LANE_ONE  = 1'b1
    } wg_lane_t;

    localparam int WG_FILT_LEN  = 3;
    localparam int WG_MIN_PULSE = 20;
    localparam int WG_MAX_PULSE = 200;
    localparam int WG_FRAME_GAP = 5000;
    localparam int WG_CNT_W     = 13;
    localparam int WG_BITS_W    = 6;

endpackage

// File: rtl/wiegand_line_frontend_if.sv
// rtl/wiegand_line_frontend_if.sv - pin, enable and strobe bundle of the Wiegand front end
interface wiegand_line_frontend_if;
    import wiegand_pkg::*;

    logic [1:0]           wil;
    logic                 enable;
    logic                 bit_vld;
    logic                 bit_val;
    logic                 frame_end;
    logic [WG_BITS_W-1:0] frame_bits;
    logic                 err_pulse;
    logic                 err_both;
    logic                 line_idle;

    // master: the front end itself; slave: pins/config source and strobe consumer
    modport master (
        input  wil, enable,
        output bit_vld, bit_val, frame_end, frame_bits, err_pulse, err_both, line_idle
    );

    modport slave (
        output wil, enable,
        input  bit_vld, bit_val, frame_end, frame_bits, err_pulse, err_both, line_idle
    );

endinterface

// File: rtl/wil_glitch_filter.sv
// rtl/wil_glitch_filter.sv - two-flop synchroniser plus run-length glitch filter for one line
module wil_glitch_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic nReset,
    input  logic raw,
    output logic level,
    output logic fell
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic [1:0]       sync;
    logic [RUN_W-1:0] run;

    // Level flips only after FILT_LEN consecutive differing samples; fell marks a 1->0 flip.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            fell  <= 1'b0;
            run   <= '0;
        end else begin
            sync <= {sync[0], raw};
            fell <= 1'b0;
            if (sync[1] == level) begin
                run <= '0;
            end else if (run == RUN_W'(FILT_LEN - 1)) begin
                run   <= '0;
                level <= sync[1];
                fell  <= ~sync[1];
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wiegand_line_frontend.sv
// rtl/wiegand_line_frontend.sv - Wiegand pulse classifier producing bit, frame and error strobes
module wiegand_line_frontend
    import wiegand_pkg::*;
#(
    parameter int FILT_LEN  = WG_FILT_LEN,
    parameter int MIN_PULSE = WG_MIN_PULSE,
    parameter int MAX_PULSE = WG_MAX_PULSE,
    parameter int FRAME_GAP = WG_FRAME_GAP,
    parameter int CNT_W     = WG_CNT_W
) (
    input  logic                    clk,
    input  logic                    nReset,
    wiegand_line_frontend_if.master wif
);

    logic [1:0]           lvl;
    logic [1:0]           fell;
    wg_state_t            state;
    wg_lane_t             lane;
    logic [CNT_W-1:0]     width;
    logic [CNT_W-1:0]     gap;
    logic [WG_BITS_W-1:0] bit_cnt;
    logic                 bit_vld_q, bit_val_q, frame_end_q, err_pulse_q, err_both_q;
    logic [WG_BITS_W-1:0] frame_bits_q;

    logic             lane_idx;
    logic             lane_lvl;
    logic             other_lvl;
    logic [CNT_W-1:0] width_inc;

    wil_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt0 (
        .clk(clk), .nReset(nReset), .raw(wif.wil[0]), .level(lvl[0]), .fell(fell[0])
    );

    wil_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt1 (
        .clk(clk), .nReset(nReset), .raw(wif.wil[1]), .level(lvl[1]), .fell(fell[1])
    );

    assign lane_idx  = lane;
    assign lane_lvl  = lvl[lane_idx];
    assign other_lvl = lvl[!lane_idx];
    // Width including the current cycle, so a pin pulse of N cycles classifies as N.
    assign width_inc = width + 1'b1;

    // Pulse FSM, bit counting and frame-gap tracking; all strobes registered and one cycle wide.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state        <= IDLE;
            lane         <= LANE_ZERO;
            width        <= '0;
            gap          <= '0;
            bit_cnt      <= '0;
            bit_vld_q    <= 1'b0;
            bit_val_q    <= 1'b0;
            frame_end_q  <= 1'b0;
            frame_bits_q <= '0;
            err_pulse_q  <= 1'b0;
            err_both_q   <= 1'b0;
        end else begin
            bit_vld_q   <= 1'b0;
            frame_end_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_both_q  <= 1'b0;
            if (!wif.enable) begin
                state   <= IDLE;
                bit_cnt <= '0;
                gap     <= '0;
            end else begin
                if (|fell) begin
                    gap <= '0;
                end else if (state == IDLE && gap != CNT_W'(FRAME_GAP)) begin
                    gap <= gap + 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (&fell) begin
                            state      <= ERR;
                            err_both_q <= 1'b1;
                        end else if (|fell) begin
                            state <= LOW;
                            lane  <= fell[1] ? LANE_ONE : LANE_ZERO;
                            width <= '0;
                        end
                    end
                    LOW: begin
                        width <= width_inc;
                        if (!other_lvl) begin
                            state      <= ERR;
                            err_both_q <= 1'b1;
                        end else if (lane_lvl) begin
                            state <= IDLE;
                            if (width_inc >= CNT_W'(MIN_PULSE) && width_inc <= CNT_W'(MAX_PULSE)) begin
                                bit_vld_q <= 1'b1;
                                bit_val_q <= lane_idx;
                                if (bit_cnt != '1) begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end else begin
                                err_pulse_q <= 1'b1;
                            end
                        end else if (width_inc == CNT_W'(MAX_PULSE + 1)) begin
                            state       <= WAIT_HIGH;
                            err_pulse_q <= 1'b1;
                        end
                    end
                    WAIT_HIGH, ERR: begin
                        if (&lvl) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // Clearing the count stops a repeat strobe while the gap counter holds.
                if (gap == CNT_W'(FRAME_GAP) && bit_cnt != '0) begin
                    frame_end_q  <= 1'b1;
                    frame_bits_q <= bit_cnt;
                    bit_cnt      <= '0;
                end
            end
        end
    end

    assign wif.bit_vld    = bit_vld_q;
    assign wif.bit_val    = bit_val_q;
    assign wif.frame_end  = frame_end_q;
    assign wif.frame_bits = frame_bits_q;
    assign wif.err_pulse  = err_pulse_q;
    assign wif.err_both   = err_both_q;
    assign wif.line_idle  = (state == IDLE) && lvl[0] && lvl[1];

endmodule
